mdio_master: RTL

- Clause-22 MDIO management master for the Ethernet PHY on the SGMII link.
- Sits between the Ethernet driver's PHY-management logic and the top-level MDIO IOBUF and MDC pin.
- Accepts one register read/write command at a time and serialises it as an IEEE 802.3 clause-22 frame on MDC/MDIO.
- Returns read data or write completion on a single-cycle response.

---
 rtl/mdio_master.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO master. Serialises one register read or write per command on MDC/MDIO
// and returns a single-cycle completion.
module mdio_master #(
   parameter int unsigned CLK_DIV       = 25,
   parameter int unsigned PREAMBLE_BITS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_error,
   output logic        eth_mdc,
   output logic        eth_mdio_o,
   output logic        eth_mdio_t,
   input  logic        eth_mdio_i
);
   localparam int unsigned BIT_CLKS = 2 * CLK_DIV;
   localparam int unsigned DIV_W    = $clog2(BIT_CLKS);
   localparam int unsigned CNT_W    = 5;

   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_TAIL} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic             r_ready;
   logic             r_rsp_valid;
   logic [15:0]      r_rsp_rdata;
   logic             r_rsp_error;
   logic             r_mdc;
   logic             r_mdio_o;
   logic             r_mdio_t;
   logic             r_write;
   logic [4:0]       r_phy;
   logic [4:0]       r_reg;
   logic [15:0]      r_wdata;
   logic [1:0]       r_sync;
   logic [15:0]      r_rd_shift;
   logic             r_ta_err;

   logic [13:0]      w_hdr;
   logic             w_accept;
   logic             w_bit_end;
   logic             w_rsp_due;
   state_t           w_nstate;
   logic [CNT_W-1:0] w_ncnt;
   logic             w_nbit_o;
   logic             w_nbit_t;

   assign cmd_ready  = r_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_error  = r_rsp_error;
   assign eth_mdc    = r_mdc;
   assign eth_mdio_o = r_mdio_o;
   assign eth_mdio_t = r_mdio_t;

   // ST is always 01, so bit 13 is a constant 0 even before the new command is latched
   assign w_hdr     = {2'b01, (r_write ? 2'b01 : 2'b10), r_phy, r_reg};
   assign w_accept  = cmd_valid && r_ready;
   assign w_bit_end = (r_div == DIV_W'(BIT_CLKS - 1));
   assign w_rsp_due = (r_state == ST_TAIL) && (r_div == DIV_W'(BIT_CLKS - 2));

   // Successor bit position; IDLE and TAIL both lead to the start of a new frame
   always_comb begin
      w_nstate = ST_IDLE;
      w_ncnt   = '0;
      case (r_state)
         ST_PRE: begin
            if (r_cnt == '0) begin
               w_nstate = ST_HDR;
               w_ncnt   = CNT_W'(13);
            end else begin
               w_nstate = ST_PRE;
               w_ncnt   = r_cnt - CNT_W'(1);
            end
         end
         ST_HDR: begin
            w_nstate = (r_cnt == '0) ? ST_TA : ST_HDR;
            w_ncnt   = (r_cnt == '0) ? CNT_W'(1) : r_cnt - CNT_W'(1);
         end
         ST_TA: begin
            w_nstate = (r_cnt == '0) ? ST_DATA : ST_TA;
            w_ncnt   = (r_cnt == '0) ? CNT_W'(15) : r_cnt - CNT_W'(1);
         end
         ST_DATA: begin
            w_nstate = (r_cnt == '0) ? ST_TAIL : ST_DATA;
            w_ncnt   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
         end
         default: begin
            if (PREAMBLE_BITS != 0) begin
               w_nstate = ST_PRE;
               w_ncnt   = CNT_W'(PREAMBLE_BITS - 1);
            end else begin
               w_nstate = ST_HDR;
               w_ncnt   = CNT_W'(13);
            end
         end
      endcase
   end

   // Line value for the successor bit; read TA/data and TAIL leave the line released
   always_comb begin
      w_nbit_o = 1'b1;
      w_nbit_t = 1'b1;
      case (w_nstate)
         ST_PRE:  w_nbit_t = 1'b0;
         ST_HDR: begin
            w_nbit_o = w_hdr[w_ncnt[3:0]];
            w_nbit_t = 1'b0;
         end
         ST_TA: begin
            if (r_write) begin
               w_nbit_o = w_ncnt[0];
               w_nbit_t = 1'b0;
            end
         end
         ST_DATA: begin
            if (r_write) begin
               w_nbit_o = r_wdata[w_ncnt[3:0]];
               w_nbit_t = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      r_sync <= {r_sync[0], eth_mdio_i};
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_div       <= '0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
         r_mdc       <= 1'b0;
         r_mdio_o    <= 1'b1;
         r_mdio_t    <= 1'b1;
         r_write     <= 1'b0;
         r_phy       <= '0;
         r_reg       <= '0;
         r_wdata     <= '0;
         r_rd_shift  <= '0;
         r_ta_err    <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_accept) begin
            r_write  <= cmd_write;
            r_phy    <= cmd_phy_addr;
            r_reg    <= cmd_reg_addr;
            r_wdata  <= cmd_wdata;
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_div    <= '0;
            r_mdc    <= 1'b0;
            r_mdio_o <= w_nbit_o;
            r_mdio_t <= w_nbit_t;
            r_ready  <= 1'b0;
            r_ta_err <= 1'b0;
         end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
               // Last clock of the MDC-high phase: sample the read line, then move to the next bit
               r_div <= '0;
               r_mdc <= 1'b0;
               if (!r_write && (r_state == ST_TA) && (r_cnt == '0))
                  r_ta_err <= r_sync[1];
               if (!r_write && (r_state == ST_DATA))
                  r_rd_shift <= {r_rd_shift[14:0], r_sync[1]};
               if (r_state == ST_TAIL) begin
                  r_state  <= ST_IDLE;
                  r_mdio_o <= 1'b1;
                  r_mdio_t <= 1'b1;
               end else begin
                  r_state  <= w_nstate;
                  r_cnt    <= w_ncnt;
                  r_mdio_o <= w_nbit_o;
                  r_mdio_t <= w_nbit_t;
               end
            end else begin
               r_div <= r_div + DIV_W'(1);
               r_mdc <= ((r_div + DIV_W'(1)) >= DIV_W'(CLK_DIV));
               if (w_rsp_due) begin
                  r_ready     <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_write ? 16'h0000 : (r_ta_err ? 16'hFFFF : r_rd_shift);
                  r_rsp_error <= !r_write && r_ta_err;
               end
            end
         end
      end
   end

endmodule
